// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } ifu_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Fetch PC register: sequential +4 advance with word-aligned redirect override.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] fetch_pc
);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] fetch_pc_s;

    // Redirect wins over a same-cycle grant: the granted word is killed anyway.
    always_comb begin
        fetch_pc_s = fetch_pc_r;
        if (redirect) begin
            fetch_pc_s = align_word(redirect_pc);
        end else if (advance) begin
            fetch_pc_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else begin
            fetch_pc_r <= fetch_pc_s;
        end
    end

    assign fetch_pc = fetch_pc_r;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, output register with valid/ready.
// Optional feature macro: IFU_EBREAK_HALT_EN (halt after an accepted EBREAK).
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    ifu_state_e      state_r;
    ifu_state_e      state_s;
    logic            kill_r;
    logic            kill_s;
    logic [XLEN-1:0] issued_pc_r;
    logic [XLEN-1:0] fetch_pc_s;
    logic            out_valid_r;
    logic [XLEN-1:0] out_pc_r;
    logic [XLEN-1:0] out_instr_r;

    logic drain_s;
    logic redirect_s;
    logic ebreak_accept_s;
    logic req_s;
    logic gnt_s;
    logic resp_s;
    logic capture_s;

    assign drain_s    = out_valid_r & out_ready;
    assign redirect_s = redirect_valid & ((state_r == REQ) | (state_r == WAIT));

`ifdef IFU_EBREAK_HALT_EN
    assign ebreak_accept_s = drain_s & (out_instr_r == INSTR_EBREAK);
`else
    assign ebreak_accept_s = 1'b0;
`endif

    // A request only goes out when its response is guaranteed a slot in the output register.
    assign req_s     = (state_r == REQ) & (~out_valid_r | drain_s) & ~ebreak_accept_s;
    assign gnt_s     = req_s & imem_gnt;
    assign resp_s    = (state_r == WAIT) & imem_rvalid;
    assign capture_s = resp_s & ~kill_r & ~redirect_s;

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .advance     (gnt_s),
        .redirect    (redirect_s),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc_s)
    );

    // Next-state and kill-flag logic.
    always_comb begin
        state_s = state_r;
        kill_s  = kill_r;
        case (state_r)
            IDLE: begin
                state_s = REQ;
                kill_s  = 1'b0;
            end
            REQ: begin
                if (ebreak_accept_s) begin
                    state_s = HALT;
                end else if (gnt_s) begin
                    state_s = WAIT;
                    kill_s  = redirect_s;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                // A redirect coinciding with the response drops it directly; no kill needed.
                if (resp_s) begin
                    state_s = REQ;
                    kill_s  = 1'b0;
                end else begin
                    state_s = WAIT;
                    kill_s  = kill_r | redirect_s;
                end
            end
            HALT: begin
                state_s = HALT;
                kill_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                kill_s  = 1'b0;
            end
        endcase
    end

    // FSM state, kill flag and PC of the outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            kill_r      <= 1'b0;
            issued_pc_r <= RESET_PC;
        end else begin
            state_r <= state_s;
            kill_r  <= kill_s;
            if (gnt_s) begin
                issued_pc_r <= fetch_pc_s;
            end
        end
    end

    // Output register: flush on redirect, load on a live response, clear on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'h0000_0000;
            out_instr_r <= INSTR_NOP;
        end else if (redirect_s) begin
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_pc_r    <= issued_pc_r;
            out_instr_r <= imem_rdata;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_s;
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_instr = out_instr_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; honours IFU_EBREAK_HALT_EN when defined.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset two cycles, release on a falling edge (state is IDLE afterwards).
    task automatic apply_reset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Grant the current request now and return data on the next cycle.
    task automatic fetch_word(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_addr got %h exp 80000000", imem_addr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 00000000", out_pc); end
        n_checks++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h exp 00000013", out_instr); end
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", imem_req); end
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] data [3];
        data[0] = 32'h1111_1113; data[1] = 32'h2222_2223; data[2] = 32'h3333_3333;
        apply_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_rel got %b exp 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_c1 got %b exp 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d] got %b exp 1", i, imem_req); end
            n_checks++; if (imem_addr !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, 32'h8000_0000 + 32'(4 * i)); end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait_valid[%0d] got %b exp 0", i, out_valid); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req[%0d] got %b exp 0", i, imem_req); end
            imem_rvalid = 1'b1;
            imem_rdata = data[i];
            tick();
            imem_rvalid = 1'b0;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b exp 1", i, out_valid); end
            n_checks++; if (out_pc !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, out_pc, 32'h8000_0000 + 32'(4 * i)); end
            n_checks++; if (out_instr !== data[i]) begin n_fail++; $display("FAIL seq_instr[%0d] got %h exp %h", i, out_instr, data[i]); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        tick();
        fetch_word(32'hAAAA_0001);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
            n_checks++; if (out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL bp_pc[%0d] got %h exp 80000000", i, out_pc); end
            n_checks++; if (out_instr !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_instr[%0d] got %h exp aaaa0001", i, out_instr); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req[%0d] got %b exp 0", i, imem_req); end
            // Stray response while not waiting must be ignored.
            imem_rvalid = (i == 2);
            imem_rdata = 32'hDEAD_BEEF;
            tick();
            imem_rvalid = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_rel_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL bp_rel_addr got %h exp 80000004", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b exp 0", out_valid); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hAAAA_0002;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (out_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL bp_next_pc got %h exp 80000004", out_pc); end
        n_checks++; if (out_instr !== 32'hAAAA_0002) begin n_fail++; $display("FAIL bp_next_instr got %h exp aaaa0002", out_instr); end
    endtask

    task automatic test_redirect();
        apply_reset();
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_wait_req got %b exp 0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_dropped got %b exp 0", out_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rd_addr got %h exp 80000100", imem_addr); end
        fetch_word(32'hCCCC_0100);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid got %b exp 1", out_valid); end
        n_checks++; if (out_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL rd_pc got %h exp 80000100", out_pc); end
        n_checks++; if (out_instr !== 32'hCCCC_0100) begin n_fail++; $display("FAIL rd_instr got %h exp cccc0100", out_instr); end
        // Redirect while the output register is full and stalled flushes it.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0202;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got %b exp 0", out_valid); end
        n_checks++; if (imem_addr !== 32'h8000_0200) begin n_fail++; $display("FAIL rd_flush_addr got %h exp 80000200", imem_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_flush_req got %b exp 1", imem_req); end
        out_ready = 1'b1;
    endtask

    task automatic test_gnt_stall();
        apply_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL st_req[%0d] got %b exp 1", i, imem_req); end
            n_checks++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL st_addr[%0d] got %h exp 80000000", i, imem_addr); end
            if (i < 4) tick();
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        n_checks++; if (imem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL st_adv got %h exp 80000004", imem_addr); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hEEEE_0000;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL st_pc got %h exp 80000000", out_pc); end
        n_checks++; if (out_instr !== 32'hEEEE_0000) begin n_fail++; $display("FAIL st_instr got %h exp eeee0000", out_instr); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rm_addr got %h exp 80000000", imem_addr); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD1_BAD1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_idle_req got %b exp 0", imem_req); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", out_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rm_addr2 got %h exp 80000000", imem_addr); end
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid2 got %b exp 0", out_valid); end
        fetch_word(32'hF0F0_0000);
        n_checks++; if (out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL rm_pc got %h exp 80000000", out_pc); end
        n_checks++; if (out_instr !== 32'hF0F0_0000) begin n_fail++; $display("FAIL rm_instr got %h exp f0f00000", out_instr); end
    endtask

    task automatic test_ebreak();
        apply_reset();
        tick();
        fetch_word(32'h0000_0013);
        fetch_word(32'h0000_0013);
        fetch_word(32'h0010_0073);
        n_checks++; if (out_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL eb_pc got %h exp 80000008", out_pc); end
        n_checks++; if (out_instr !== 32'h0010_0073) begin n_fail++; $display("FAIL eb_instr got %h exp 00100073", out_instr); end
`ifdef IFU_EBREAK_HALT_EN
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL eb_halt_req0 got %b exp 0", imem_req); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0300;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL eb_halt_req[%0d] got %b exp 0", i, imem_req); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eb_halt_valid[%0d] got %b exp 0", i, out_valid); end
            imem_gnt = 1'b1;
            tick();
            redirect_valid = 1'b0;
        end
        imem_gnt = 1'b0;
`else
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL eb_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h8000_000C) begin n_fail++; $display("FAIL eb_addr got %h exp 8000000c", imem_addr); end
        fetch_word(32'h1234_5678);
        n_checks++; if (out_pc !== 32'h8000_000C) begin n_fail++; $display("FAIL eb_next_pc got %h exp 8000000c", out_pc); end
        n_checks++; if (out_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL eb_next_instr got %h exp 12345678", out_instr); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_gnt_stall();
        test_reset_mid_wait();
        test_ebreak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
